// File: rtl/minmax_pkg.sv
// Shared types and node logic for the pipelined min/max reduction tree.
// Struct widths follow the MM_* localparams; the top-level parameters must match them.
package minmax_pkg;

    localparam int MM_WIDTH       = 8;
    localparam int MM_INDEX_WIDTH = 3;
    localparam int MM_USER_WIDTH  = 4;
    localparam int LEAVES         = 1 << MM_INDEX_WIDTH;

    typedef struct packed {
        logic [MM_WIDTH-1:0]       value;
        logic [MM_INDEX_WIDTH-1:0] index;
        logic                      mask;
    } node_t;

    typedef struct packed {
        logic                     tc;
        logic                     max;
        logic [MM_USER_WIDTH-1:0] user;
    } ctrl_t;

    // Flipping the MSB maps two's-complement order onto unsigned order; it is its own inverse.
    function automatic logic [MM_WIDTH-1:0] bias_msb(input logic [MM_WIDTH-1:0] v, input logic tc);
        logic [MM_WIDTH-1:0] m;
        m = '0;
        m[MM_WIDTH-1] = tc;
        return v ^ m;
    endfunction

    // The higher-index node must win strictly, so ties always resolve to the lower index.
    function automatic node_t node_pick(input node_t lo, input node_t hi, input logic max);
        logic hi_wins;
        if (lo.mask && hi.mask) begin
            hi_wins = max ? (hi.value > lo.value) : (hi.value < lo.value);
        end else begin
            hi_wins = hi.mask && !lo.mask;
        end
        return hi_wins ? hi : lo;
    endfunction

endpackage

// File: rtl/minmax_stage.sv
// One tree level: pairwise compare nodes feeding this level's pipeline register.
// Optional MINMAX_USER_EN adds a registered sideband tag.
module minmax_stage
    import minmax_pkg::*;
#(
    parameter int LEVEL = 0
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  adv_i,
    input  logic                                  vld_i,
    input  ctrl_t                                 ctrl_i,
    input  node_t [(LEAVES >> LEVEL)-1:0]         nodes_i,
    output logic                                  vld_o,
    output ctrl_t                                 ctrl_o,
    output node_t [(LEAVES >> (LEVEL + 1))-1:0]   nodes_o
);

    localparam int N_OUT = LEAVES >> (LEVEL + 1);

    node_t [N_OUT-1:0]        nodes_d;
    node_t [N_OUT-1:0]        nodes_q;
    logic                     vld_q;
    logic                     tc_q;
    logic                     max_q;
    logic [MM_USER_WIDTH-1:0] user_q;

    always_comb begin
        nodes_d = '0;
        for (int n = 0; n < N_OUT; n++) begin
            nodes_d[n] = node_pick(nodes_i[2*n], nodes_i[2*n+1], ctrl_i.max);
        end
    end

    // Only the valid bit is reset; payload is qualified by it downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= 1'b0;
        end else if (adv_i) begin
            vld_q <= vld_i;
        end
    end

    always_ff @(posedge clk) begin
        if (adv_i) begin
            nodes_q <= nodes_d;
            tc_q    <= ctrl_i.tc;
            max_q   <= ctrl_i.max;
        end
    end

`ifdef MINMAX_USER_EN
    always_ff @(posedge clk) begin
        if (adv_i) begin
            user_q <= ctrl_i.user;
        end
    end
`else
    logic unused_user;
    assign unused_user = ^ctrl_i.user;
    assign user_q      = '0;
`endif

    assign vld_o   = vld_q;
    assign ctrl_o  = '{tc: tc_q, max: max_q, user: user_q};
    assign nodes_o = nodes_q;

endmodule

// File: rtl/minmax_pipe.sv
// Pipelined, flow-controlled min/max reduction with index, mask and signed/unsigned select.
// Define MINMAX_USER_EN to carry in_user through the pipe to out_user.
module minmax_pipe
    import minmax_pkg::*;
#(
    parameter int WIDTH       = MM_WIDTH,
    parameter int NUM_INPUTS  = 8,
    parameter int INDEX_WIDTH = MM_INDEX_WIDTH,
    parameter int USER_WIDTH  = MM_USER_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NUM_INPUTS*WIDTH-1:0] in_data,
    input  logic [NUM_INPUTS-1:0]       in_mask,
    input  logic                        in_tc,
    input  logic                        in_max,
    input  logic [USER_WIDTH-1:0]       in_user,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            out_value,
    output logic [INDEX_WIDTH-1:0]      out_index,
    output logic                        out_none,
    output logic [USER_WIDTH-1:0]       out_user
);

    node_t [LEAVES-1:0] leaf;
    ctrl_t              ctrl_in;
    logic               advance;
    logic               vld_root;
    ctrl_t              ctrl_root;
    node_t              root;
    logic               show;

    // Slots beyond NUM_INPUTS are masked zero padding and can never win.
    for (genvar n = 0; n < LEAVES; n++) begin : g_leaf
        if (n < NUM_INPUTS) begin : g_real
            assign leaf[n] = '{value: bias_msb(in_data[n*WIDTH +: WIDTH], in_tc),
                               index: MM_INDEX_WIDTH'(n),
                               mask:  in_mask[n]};
        end else begin : g_pad
            assign leaf[n] = '0;
        end
    end

`ifdef MINMAX_USER_EN
    assign ctrl_in = '{tc: in_tc, max: in_max, user: in_user};
`else
    logic unused_in_user;
    assign unused_in_user = ^in_user;
    assign ctrl_in        = '{tc: in_tc, max: in_max, user: '0};
`endif

    for (genvar k = 0; k < INDEX_WIDTH; k++) begin : g_lvl
        localparam int N_OUT = LEAVES >> (k + 1);
        node_t [N_OUT-1:0] nodes;
        ctrl_t             ctrl;
        logic              vld;
        if (k == 0) begin : g_first
            minmax_stage #(.LEVEL(0)) u_stage (
                .clk     (clk),
                .rst     (rst),
                .adv_i   (advance),
                .vld_i   (in_valid),
                .ctrl_i  (ctrl_in),
                .nodes_i (leaf),
                .vld_o   (vld),
                .ctrl_o  (ctrl),
                .nodes_o (nodes)
            );
        end else begin : g_next
            minmax_stage #(.LEVEL(k)) u_stage (
                .clk     (clk),
                .rst     (rst),
                .adv_i   (advance),
                .vld_i   (g_lvl[k-1].vld),
                .ctrl_i  (g_lvl[k-1].ctrl),
                .nodes_i (g_lvl[k-1].nodes),
                .vld_o   (vld),
                .ctrl_o  (ctrl),
                .nodes_o (nodes)
            );
        end
    end

    assign vld_root  = g_lvl[INDEX_WIDTH-1].vld;
    assign ctrl_root = g_lvl[INDEX_WIDTH-1].ctrl;
    assign root      = g_lvl[INDEX_WIDTH-1].nodes[0];

    // Whole-pipe stall: every stage moves together, bubbles included.
    assign advance  = out_ready || !vld_root;
    assign in_ready = advance && !rst;

    assign out_valid = vld_root && !rst;
    assign show      = out_valid && root.mask;
    assign out_value = show ? bias_msb(root.value, ctrl_root.tc) : '0;
    assign out_index = show ? root.index : '0;
    assign out_none  = out_valid && !root.mask;
    assign out_user  = out_valid ? ctrl_root.user : '0;

endmodule

// File: tb/tb_minmax_pipe.sv
// Scoreboard bench for minmax_pipe: an 8-input instance plus a 5-input instance (padding cases).
`timescale 1ns/1ps
module tb_minmax_pipe;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, in_ready, in_tc, in_max, out_valid, out_ready, out_none;
    logic [63:0] in_data;
    logic [7:0]  in_mask, out_value;
    logic [3:0]  in_user, out_user;
    logic [2:0]  out_index;

    logic        v5, r5, mx5, o5_valid, o5_none;
    logic        tc5 = 1'b0;
    logic        ordy5 = 1'b1;
    logic [3:0]  u5 = 4'h0;
    logic [39:0] d5;
    logic [4:0]  m5;
    logic [7:0]  o5_value;
    logic [2:0]  o5_index;
    logic [3:0]  o5_user;

    minmax_pipe u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_mask(in_mask), .in_tc(in_tc), .in_max(in_max), .in_user(in_user),
        .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value),
        .out_index(out_index), .out_none(out_none), .out_user(out_user)
    );

    minmax_pipe #(.NUM_INPUTS(5)) u_dut5 (
        .clk(clk), .rst(rst), .in_valid(v5), .in_ready(r5), .in_data(d5),
        .in_mask(m5), .in_tc(tc5), .in_max(mx5), .in_user(u5),
        .out_valid(o5_valid), .out_ready(ordy5), .out_value(o5_value),
        .out_index(o5_index), .out_none(o5_none), .out_user(o5_user)
    );

    typedef struct packed {
        logic [7:0] v;
        logic [2:0] i;
        logic       none;
        logic [3:0] u;
        int         acc;
        logic       lat;
        int         id;
    } exp_t;

    exp_t q8[$];
    exp_t q5[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   beat_id = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s beat=%0d: got %0h, expected %0h", nm, id, act, exp);
        end
    endtask

    function automatic logic [63:0] pk(input logic [7:0] a0, a1, a2, a3, a4, a5, a6, a7);
        return {a7, a6, a5, a4, a3, a2, a1, a0};
    endfunction

    task automatic send8(input logic [63:0] d, input logic [7:0] m, input logic tc, input logic mx,
                         input logic [3:0] u, input logic [7:0] ev, input logic [2:0] ei,
                         input logic en, input logic lat);
        logic       ok;
        logic [3:0] eu;
`ifdef MINMAX_USER_EN
        eu = u;
`else
        eu = 4'h0;
`endif
        beat_id++;
        in_data = d; in_mask = m; in_tc = tc; in_max = mx; in_user = u; in_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                q8.push_back('{v: ev, i: ei, none: en, u: eu, acc: cyc + 1, lat: lat, id: beat_id});
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL accept8 beat=%0d: in_ready never high, expected acceptance", beat_id);
        end
    endtask

    task automatic send5(input logic [39:0] d, input logic [4:0] m, input logic mx,
                         input logic [7:0] ev, input logic [2:0] ei, input logic en);
        logic ok;
        beat_id++;
        d5 = d; m5 = m; mx5 = mx; v5 = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            if (r5) begin
                ok = 1'b1;
                q5.push_back('{v: ev, i: ei, none: en, u: 4'h0, acc: cyc + 1, lat: 1'b1, id: beat_id});
            end
            @(posedge clk); #1;
        end
        v5 = 1'b0;
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL accept5 beat=%0d: in_ready never high, expected acceptance", beat_id);
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 60 && (q8.size() != 0 || q5.size() != 0); t++) @(posedge clk);
        #1;
        if (q8.size() != 0 || q5.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain: %0d/%0d results outstanding, expected 0", q8.size(), q5.size());
            q8.delete(); q5.delete();
        end
    endtask

    // Monitor for the 8-input instance, including output stability under stall.
    initial begin : mon8
        exp_t       e;
        logic       stalled;
        logic [7:0] hv;
        logic [2:0] hi;
        logic       hn;
        logic [3:0] hu;
        stalled = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    chk("hold_valid", -1, 32'(out_valid), 32'd1);
                    chk("hold_value", -1, 32'(out_value), 32'(hv));
                    chk("hold_index", -1, 32'(out_index), 32'(hi));
                    chk("hold_none",  -1, 32'(out_none),  32'(hn));
                    chk("hold_user",  -1, 32'(out_user),  32'(hu));
                end
                stalled = out_valid && !out_ready;
                hv = out_value; hi = out_index; hn = out_none; hu = out_user;
                if (out_valid && out_ready) begin
                    if (q8.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_out8: got value %0h index %0d, expected no output", out_value, out_index);
                    end else begin
                        e = q8.pop_front();
                        chk("value", e.id, 32'(out_value), 32'(e.v));
                        chk("index", e.id, 32'(out_index), 32'(e.i));
                        chk("none",  e.id, 32'(out_none),  32'(e.none));
                        chk("user",  e.id, 32'(out_user),  32'(e.u));
                        if (e.lat) chk("latency", e.id, 32'(cyc + 1 - e.acc), 32'd3);
                    end
                end
            end
        end
    end

    initial begin : mon5
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && o5_valid) begin
                if (q5.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_out5: got value %0h index %0d, expected no output", o5_value, o5_index);
                end else begin
                    e = q5.pop_front();
                    chk("value5",   e.id, 32'(o5_value), 32'(e.v));
                    chk("index5",   e.id, 32'(o5_index), 32'(e.i));
                    chk("none5",    e.id, 32'(o5_none),  32'(e.none));
                    chk("latency5", e.id, 32'(cyc + 1 - e.acc), 32'd3);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] va, vb, vc, vd;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mask = '0; in_tc = 1'b0; in_max = 1'b0;
        in_user = '0; out_ready = 1'b1; v5 = 1'b0; d5 = '0; m5 = '0; mx5 = 1'b0;
        va = pk(3, 9, 2, 9, 0, 1, 7, 5);
        vb = pk(3, 9, 2, 9, 8'h80, 1, 7, 5);
        vc = pk(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        vd = pk(5, 3, 3, 8, 8, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 0, 32'(out_valid), 32'd0);
        chk("rst_in_ready",  0, 32'(in_ready),  32'd0);
        chk("rst_out_value", 0, 32'(out_value), 32'd0);
        chk("rst_out_index", 0, 32'(out_index), 32'd0);
        chk("rst_out_none",  0, 32'(out_none),  32'd0);
        chk("rst_out_user",  0, 32'(out_user),  32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        send8(va, 8'hFF, 0, 1, 4'h1, 8'd9,   3'd1, 0, 1);
        send8(vb, 8'hFF, 1, 0, 4'h2, 8'h80,  3'd4, 0, 1);
        send8(vb, 8'hFF, 0, 0, 4'h3, 8'd1,   3'd5, 0, 1);
        send8(va, 8'h00, 0, 1, 4'h4, 8'd0,   3'd0, 1, 1);
        send8(va, 8'h40, 0, 1, 4'h5, 8'd7,   3'd6, 0, 1);
        send8(va, 8'h40, 0, 0, 4'h6, 8'd7,   3'd6, 0, 1);
        send8(vb, 8'hFF, 1, 1, 4'h7, 8'd9,   3'd1, 0, 1);
        send8(vb, 8'hFF, 0, 1, 4'h8, 8'h80,  3'd4, 0, 1);
        send8(vc, 8'hFF, 1, 0, 4'h9, 8'hFF,  3'd0, 0, 1);
        send8(vc, 8'hFF, 0, 1, 4'hA, 8'hFF,  3'd0, 0, 1);
        send8(vd, 8'h1E, 0, 1, 4'hB, 8'd8,   3'd3, 0, 1);
        send8(vd, 8'h1E, 0, 0, 4'hC, 8'd3,   3'd1, 0, 1);
        send8(vb, 8'hEF, 1, 0, 4'hD, 8'd1,   3'd5, 0, 1);
        send8(va, 8'h80, 0, 0, 4'hE, 8'd5,   3'd7, 0, 1);
        drain();

        send5(40'h04_04_04_04_04, 5'h1F, 1, 8'd4, 3'd0, 0);
        send5(40'h04_04_04_04_04, 5'h1F, 0, 8'd4, 3'd0, 0);
        send5(40'h05_04_03_02_01, 5'h1F, 1, 8'd5, 3'd4, 0);
        send5(40'h05_04_03_02_01, 5'h10, 0, 8'd5, 3'd4, 0);
        send5(40'h00_00_00_00_00, 5'h1F, 0, 8'd0, 3'd0, 0);
        send5(40'h05_04_03_02_01, 5'h00, 1, 8'd0, 3'd0, 1);
        drain();

        // Backpressure: 4-cycle downstream stall in the middle of a 6-beat stream.
        fork
            begin
                repeat (3) @(posedge clk);
                #2 out_ready = 1'b0;
                @(negedge clk);
                chk("stall_in_ready", -1, 32'(in_ready), 32'd0);
                repeat (4) @(posedge clk);
                #2 out_ready = 1'b1;
            end
        join_none
        for (int k = 1; k <= 6; k++) begin
            logic [63:0] d;
            d = '0;
            d[k*8 +: 8] = 8'(16 * k);
            send8(d, 8'hFF, 0, 1, 4'(k), 8'(16 * k), 3'(k), 0, 0);
        end
        drain();

        // Reset with two beats in flight: neither may emerge.
        send8(va, 8'hFF, 0, 1, 4'h1, 8'd9, 3'd1, 0, 0);
        send8(va, 8'hFF, 0, 0, 4'h2, 8'd0, 3'd4, 0, 0);
        rst = 1'b1;
        q8.delete();
        @(negedge clk);
        chk("midrst_in_ready",  -1, 32'(in_ready),  32'd0);
        chk("midrst_out_valid", -1, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            chk("post_rst_quiet", -1, 32'(out_valid), 32'd0);
        end
        @(posedge clk); #1;
        send8(vb, 8'hFF, 1, 0, 4'h3, 8'h80, 3'd4, 0, 1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
